// File: rtl/rgb_pwm_sequencer.sv
// rgb_pwm_sequencer: multi-channel PWM generator with off/static/blink/breathe
// lighting effects. Duty and mode are captured into a shadow on i_load and
// only take effect at a PWM period boundary, so a running period is never cut
// short or stretched. All outputs are registered.

module rgb_pwm_sequencer #(
    parameter int CHANNELS      = 3,
    parameter int PWM_WIDTH     = 8,
    parameter int BLINK_PERIODS = 64,
    parameter int STEP_PERIODS  = 2
) (
    input  logic                            i_clk,
    input  logic                            i_rst,
    input  logic                            i_load,
    input  logic [CHANNELS*PWM_WIDTH-1:0]   i_duty,
    input  logic [1:0]                      i_mode,
    output logic [CHANNELS-1:0]             o_pwm,
    output logic                            o_period_start,
    output logic                            o_pending
);

    localparam int W        = PWM_WIDTH;
    localparam int DW       = CHANNELS * PWM_WIDTH;
    localparam int BLINK_CW = (BLINK_PERIODS > 1) ? $clog2(BLINK_PERIODS) : 1;
    localparam int STEP_CW  = (STEP_PERIODS > 1) ? $clog2(STEP_PERIODS) : 1;

    localparam logic [W-1:0]        CNT_MAX    = '1;
    localparam logic [W-1:0]        CNT_ZERO   = '0;
    localparam logic [W-1:0]        CNT_ONE    = W'(1);
    localparam logic [BLINK_CW-1:0] BLINK_LAST = BLINK_CW'(BLINK_PERIODS - 1);
    localparam logic [BLINK_CW-1:0] BLINK_ZERO = '0;
    localparam logic [BLINK_CW-1:0] BLINK_ONE  = BLINK_CW'(1);
    localparam logic [STEP_CW-1:0]  STEP_LAST  = STEP_CW'(STEP_PERIODS - 1);
    localparam logic [STEP_CW-1:0]  STEP_ZERO  = '0;
    localparam logic [STEP_CW-1:0]  STEP_ONE   = STEP_CW'(1);

    typedef enum logic [1:0] {
        MODE_OFF     = 2'd0,
        MODE_STATIC  = 2'd1,
        MODE_BLINK   = 2'd2,
        MODE_BREATHE = 2'd3
    } mode_e;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    // Effective duty of one channel for a given mode and effect state.
    // Breathe uses the full double-width product and keeps the upper half.
    function automatic logic [W-1:0] eff_calc(
        input mode_e        mode,
        input logic [W-1:0] duty,
        input logic         blink_on,
        input logic [W-1:0] scale
    );
        logic [2*W-1:0] prod;
        logic [W-1:0]   res;
        prod = {{W{1'b0}}, duty} * {{W{1'b0}}, scale};
        case (mode)
            MODE_OFF:     res = CNT_ZERO;
            MODE_STATIC:  res = duty;
            MODE_BLINK:   res = blink_on ? duty : CNT_ZERO;
            MODE_BREATHE: res = prod[2*W-1:W];
            default:      res = CNT_ZERO;
        endcase
        return res;
    endfunction

    // Period counter and boundary
    logic [W-1:0]          cnt_r;
    logic                  boundary_s;

    // Shadow (load side)
    logic [DW-1:0]         shadow_duty_r;
    mode_e                 shadow_mode_r;
    logic                  pending_r;
    logic                  pending_nxt_s;

    // Active (committed) settings
    logic [DW-1:0]         duty_r;
    logic [DW-1:0]         duty_nxt_s;
    mode_e                 mode_r;
    mode_e                 mode_nxt_s;
    logic                  commit_s;
    logic                  mode_change_s;

    // Effect state
    logic                  blink_on_r;
    logic                  blink_on_nxt_s;
    logic [BLINK_CW-1:0]   blink_cnt_r;
    logic [BLINK_CW-1:0]   blink_cnt_nxt_s;
    logic [W-1:0]          scale_r;
    logic [W-1:0]          scale_nxt_s;
    dir_e                  dir_r;
    dir_e                  dir_nxt_s;
    logic [STEP_CW-1:0]    step_cnt_r;
    logic [STEP_CW-1:0]    step_cnt_nxt_s;

    // Effective duty and outputs
    logic [DW-1:0]         eff_r;
    logic [DW-1:0]         eff_nxt_s;
    logic [CHANNELS-1:0]   pwm_r;
    logic [CHANNELS-1:0]   pwm_nxt_s;
    logic                  period_start_r;

    assign boundary_s    = (cnt_r == CNT_MAX);
    assign commit_s      = boundary_s & pending_r;
    assign mode_change_s = commit_s & (shadow_mode_r != mode_r);

    // Pending flag: a load always (re)arms it, even on the boundary clock, so
    // a boundary-coincident load waits for the following boundary.
    always_comb begin
        pending_nxt_s = pending_r;
        if (i_load) begin
            pending_nxt_s = 1'b1;
        end else if (boundary_s) begin
            pending_nxt_s = 1'b0;
        end else begin
            pending_nxt_s = pending_r;
        end
    end

    // Commit and effect-state next values; everything here moves only at a boundary.
    always_comb begin
        duty_nxt_s      = duty_r;
        mode_nxt_s      = mode_r;
        blink_on_nxt_s  = blink_on_r;
        blink_cnt_nxt_s = blink_cnt_r;
        scale_nxt_s     = scale_r;
        dir_nxt_s       = dir_r;
        step_cnt_nxt_s  = step_cnt_r;

        if (commit_s) begin
            duty_nxt_s = shadow_duty_r;
            mode_nxt_s = shadow_mode_r;
        end else begin
            duty_nxt_s = duty_r;
            mode_nxt_s = mode_r;
        end

        if (mode_change_s) begin
            // Entering a new mode always starts its effect from the beginning.
            blink_on_nxt_s  = 1'b1;
            blink_cnt_nxt_s = BLINK_ZERO;
            scale_nxt_s     = CNT_ZERO;
            dir_nxt_s       = DIR_UP;
            step_cnt_nxt_s  = STEP_ZERO;
        end else if (boundary_s) begin
            case (mode_nxt_s)
                MODE_BLINK: begin
                    if (blink_cnt_r == BLINK_LAST) begin
                        blink_cnt_nxt_s = BLINK_ZERO;
                        blink_on_nxt_s  = ~blink_on_r;
                    end else begin
                        blink_cnt_nxt_s = blink_cnt_r + BLINK_ONE;
                    end
                end
                MODE_BREATHE: begin
                    if (step_cnt_r == STEP_LAST) begin
                        step_cnt_nxt_s = STEP_ZERO;
                        // Triangle: each endpoint is visited for exactly one step.
                        case (dir_r)
                            DIR_UP: begin
                                scale_nxt_s = scale_r + CNT_ONE;
                                if (scale_r + CNT_ONE == CNT_MAX) begin
                                    dir_nxt_s = DIR_DOWN;
                                end else begin
                                    dir_nxt_s = DIR_UP;
                                end
                            end
                            DIR_DOWN: begin
                                scale_nxt_s = scale_r - CNT_ONE;
                                if (scale_r - CNT_ONE == CNT_ZERO) begin
                                    dir_nxt_s = DIR_UP;
                                end else begin
                                    dir_nxt_s = DIR_DOWN;
                                end
                            end
                            default: begin
                                scale_nxt_s = CNT_ZERO;
                                dir_nxt_s   = DIR_UP;
                            end
                        endcase
                    end else begin
                        step_cnt_nxt_s = step_cnt_r + STEP_ONE;
                    end
                end
                default: begin
                    blink_on_nxt_s = blink_on_r;
                end
            endcase
        end else begin
            blink_on_nxt_s = blink_on_r;
        end
    end

    // Effective duty per channel, computed from the post-boundary settings.
    always_comb begin
        eff_nxt_s = eff_r;
        if (boundary_s) begin
            for (int k = 0; k < CHANNELS; k++) begin
                eff_nxt_s[k*W +: W] = eff_calc(mode_nxt_s, duty_nxt_s[k*W +: W],
                                               blink_on_nxt_s, scale_nxt_s);
            end
        end else begin
            eff_nxt_s = eff_r;
        end
    end

    // PWM compare against the current count; registered on the next edge.
    always_comb begin
        pwm_nxt_s = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            pwm_nxt_s[k] = (cnt_r < eff_r[k*W +: W]);
        end
    end

    // All state registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_r          <= CNT_ZERO;
            shadow_duty_r  <= '0;
            shadow_mode_r  <= MODE_OFF;
            pending_r      <= 1'b0;
            duty_r         <= '0;
            mode_r         <= MODE_OFF;
            blink_on_r     <= 1'b1;
            blink_cnt_r    <= BLINK_ZERO;
            scale_r        <= CNT_ZERO;
            dir_r          <= DIR_UP;
            step_cnt_r     <= STEP_ZERO;
            eff_r          <= '0;
            pwm_r          <= '0;
            period_start_r <= 1'b0;
        end else begin
            cnt_r <= cnt_r + CNT_ONE;
            if (i_load) begin
                shadow_duty_r <= i_duty;
                shadow_mode_r <= mode_e'(i_mode);
            end
            pending_r      <= pending_nxt_s;
            duty_r         <= duty_nxt_s;
            mode_r         <= mode_nxt_s;
            blink_on_r     <= blink_on_nxt_s;
            blink_cnt_r    <= blink_cnt_nxt_s;
            scale_r        <= scale_nxt_s;
            dir_r          <= dir_nxt_s;
            step_cnt_r     <= step_cnt_nxt_s;
            eff_r          <= eff_nxt_s;
            pwm_r          <= pwm_nxt_s;
            period_start_r <= (cnt_r == CNT_ZERO);
        end
    end

    assign o_pwm          = pwm_r;
    assign o_period_start = period_start_r;
    assign o_pending      = pending_r;

endmodule
